// File: rtl/miss_arb_pkg.sv
// rtl/miss_arb_pkg.sv - shared state type and block geometry for the cache miss arbiter
package miss_arb_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE
  } state_t;

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - word-index counter with synchronous clear, enable and terminal-count flag
module fill_counter
  import miss_arb_pkg::*;
#(
  parameter int LAST = BLOCK_WORDS - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST[WORD_IDX_W-1:0]);

endmodule

// File: rtl/miss_arbiter.sv
// rtl/miss_arbiter.sv - arbitrates I/D cache block fills and write-through stores onto one memory port
// Optional MISS_ARB_ROUND_ROBIN_EN: alternate I/D on tied miss requests instead of fixed D priority.
module miss_arbiter #(
  parameter int BLOCK_WORDS = miss_arb_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss_req,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss_req,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        fill_we_i,
  output logic        fill_we_d,
  output logic        fill_done_i,
  output logic        fill_done_d,
  output logic        wr_ack
);

  import miss_arb_pkg::*;

  state_t                  state, state_nxt;
  logic [15:0]             base_addr;
  logic [15:0]             wr_data;
  logic                    issue_done;
  logic [WORD_IDX_W-1:0]   issue_cnt, ret_cnt;
  logic                    issue_tc, ret_tc;
  logic                    filling, issue_en, ret_en, cnt_clr;
  logic                    d_wins;

  assign filling  = (state == FILL_I) || (state == FILL_D);
  assign issue_en = filling && !issue_done;
  assign ret_en   = filling && mem_data_valid;
  assign cnt_clr  = (state == IDLE);

  fill_counter #(.LAST(BLOCK_WORDS - 1)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (issue_en),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  fill_counter #(.LAST(BLOCK_WORDS - 1)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (ret_en),
    .count (ret_cnt),
    .tc    (ret_tc)
  );

`ifdef MISS_ARB_ROUND_ROBIN_EN
  // Remembers which cache the most recent fill served; resets to "I" so D wins the first tie.
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && state_nxt == FILL_D) begin
      last_d <= 1'b1;
    end else if (state == IDLE && state_nxt == FILL_I) begin
      last_d <= 1'b0;
    end
  end

  assign d_wins = d_miss_req && (!i_miss_req || !last_d);
`else
  assign d_wins = d_miss_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_addr  <= '0;
      wr_data    <= '0;
      issue_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        issue_done <= 1'b0;
        if (d_wr_req) begin
          base_addr <= d_wr_addr;
          wr_data   <= d_wr_data;
        end else if (d_wins) begin
          base_addr <= d_miss_addr;
        end else if (i_miss_req) begin
          base_addr <= i_miss_addr;
        end
      end else if (issue_en && issue_tc) begin
        issue_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    fill_we_i   = 1'b0;
    fill_we_d   = 1'b0;
    fill_done_i = 1'b0;
    fill_done_d = 1'b0;
    wr_ack      = 1'b0;
    case (state)
      IDLE: begin
        if (d_wr_req)        state_nxt = WRITE;
        else if (d_wins)     state_nxt = FILL_D;
        else if (i_miss_req) state_nxt = FILL_I;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = base_addr;
        mem_wdata = wr_data;
        wr_ack    = 1'b1;
        state_nxt = IDLE;
      end
      FILL_I, FILL_D: begin
        // Word index replaces bits [3:1] so the burst never carries out of its block.
        mem_en = !issue_done;
        if (!issue_done) begin
          mem_addr = {base_addr[15:WORD_IDX_W+1], issue_cnt, 1'b0};
        end
        fill_word = ret_cnt;
        if (mem_data_valid) begin
          fill_data = mem_rdata;
          if (state == FILL_D) begin
            fill_we_d   = 1'b1;
            fill_done_d = ret_tc;
          end else begin
            fill_we_i   = 1'b1;
            fill_done_i = ret_tc;
          end
          if (ret_tc) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
